// File: rtl/minibyte_cpu_wide_if.sv
// Memory/IO bus of the minibyte accumulator core: req/ready handshake,
// address, read data and store data with write/drive strobes.
interface minibyte_cpu_wide_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              mem_ready_in;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              we_out;
    logic              drive_out;
    logic              req_out;

    modport master (
        input  data_in, mem_ready_in,
        output addr_out, data_out, we_out, drive_out, req_out
    );
    modport slave (
        output data_in, mem_ready_in,
        input  addr_out, data_out, we_out, drive_out, req_out
    );
endinterface

// File: rtl/minibyte_cpu_wide.sv
// Parametrised minibyte accumulator CPU: FETCH/OPERAND/MEM/HALT sequencer,
// wait-state tolerant req/ready bus and a DFT debug mux on the address bus.
module minibyte_cpu_wide #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] tm_control,
    output logic       halted_out,
    minibyte_cpu_wide_if.master bus
);
    localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LDA = 4'h2, OP_STA = 4'h3,
                           OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
                           OP_XOR = 4'h8, OP_JMP = 4'h9, OP_BZ  = 4'hA, OP_BN  = 4'hB,
                           OP_HLT = 4'hF;

    typedef enum logic [1:0] {S_FETCH = 2'd0, S_OPERAND = 2'd1, S_MEM = 2'd2, S_HALT = 2'd3} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] a, ir, alu, dbg;
    logic [ADDR_W-1:0] pc, m, opnd, addr_norm;
    logic              z, n, xfer;
    logic [3:0]        op, op_new;
    logic              unused_bits;

    assign op     = ir[DATA_W-1 -: 4];
    assign op_new = bus.data_in[DATA_W-1 -: 4];
    assign opnd   = bus.data_in[ADDR_W-1:0];
    assign xfer   = bus.req_out & bus.mem_ready_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= S_FETCH;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.req_out   = 1'b0;
        bus.we_out    = 1'b0;
        bus.drive_out = 1'b0;
        addr_norm     = pc;
        halted_out    = 1'b0;
        case (state)
            S_FETCH: begin
                bus.req_out = 1'b1;
                if (bus.mem_ready_in) begin
                    if (op_new == OP_HLT)                             state_nx = S_HALT;
                    else if (op_new inside {OP_NOP, 4'hC, 4'hD, 4'hE}) state_nx = S_FETCH;
                    else                                              state_nx = S_OPERAND;
                end
            end
            S_OPERAND: begin
                bus.req_out = 1'b1;
                if (bus.mem_ready_in)
                    state_nx = (op inside {[OP_LDA:OP_XOR]}) ? S_MEM : S_FETCH;
            end
            S_MEM: begin
                bus.req_out   = 1'b1;
                addr_norm     = m;
                bus.we_out    = (op == OP_STA);
                bus.drive_out = (op == OP_STA);
                if (bus.mem_ready_in) state_nx = S_FETCH;
            end
            default: halted_out = 1'b1;
        endcase
    end

    // LDI and LDA pass the bus word straight through
    always_comb begin
        case (op)
            OP_ADD:  alu = a + bus.data_in;
            OP_SUB:  alu = a - bus.data_in;
            OP_AND:  alu = a & bus.data_in;
            OP_OR:   alu = a | bus.data_in;
            OP_XOR:  alu = a ^ bus.data_in;
            default: alu = bus.data_in;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            a  <= '0;
            m  <= '0;
            ir <= '0;
            z  <= 1'b0;
            n  <= 1'b0;
            pc <= RST_PC;
        end else if (xfer) begin
            case (state)
                S_FETCH: begin
                    ir <= bus.data_in;
                    pc <= pc + ADDR_W'(1);
                end
                S_OPERAND: begin
                    pc <= pc + ADDR_W'(1);
                    case (op)
                        OP_LDI: begin
                            a <= alu;
                            z <= (alu == '0);
                            n <= alu[DATA_W-1];
                        end
                        OP_JMP: pc <= opnd;
                        OP_BZ:  if (z) pc <= opnd;
                        OP_BN:  if (n) pc <= opnd;
                        OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: m <= opnd;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (op != OP_STA) begin
                        a <= alu;
                        z <= (alu == '0);
                        n <= alu[DATA_W-1];
                    end
                end
                default: ;
            endcase
        end
    end

    // Debug values are built DATA_W wide and truncated onto the address bus
    always_comb begin
        dbg = '0;
        case (tm_control[2:0])
            3'd1:    dbg = a;
            3'd2:    dbg[0] = a[DATA_W-1];
            3'd3:    dbg[ADDR_W-1:0] = m;
            3'd4:    dbg[ADDR_W-1:0] = pc;
            3'd5:    dbg = ir;
            3'd6:    dbg[1:0] = {z, n};
            3'd7:    dbg[1:0] = state;
            default: dbg[ADDR_W-1:0] = addr_norm;
        endcase
    end

    assign bus.addr_out = dbg[ADDR_W-1:0];
    assign bus.data_out = a;
    assign unused_bits  = ^{tm_control[7:3], dbg};
endmodule
